// File: rtl/adiabatic_inv_chain_pkg.sv
// Shared types for the adiabatic inverter chain: power-clock phase encoding
// and the per-stage phase offset helper.
package adiabatic_pkg;

    typedef enum logic [1:0] {
        PC_WAIT,
        PC_EVAL,
        PC_HOLD,
        PC_RECOVER
    } pc_phase_t;

    // Stage k runs k phases behind the global generator phase g.
    function automatic pc_phase_t phase_of(input logic [1:0] g, input int k);
        logic [1:0] off;
        off = 2'(k % 4);
        return pc_phase_t'(g - off);
    endfunction

endpackage

// File: rtl/adiabatic_inv_chain_if.sv
// Data/handshake bundle of the adiabatic inverter chain.
// master drives en/in; slave returns in_ack, out, out_valid, pc_level.
interface adiabatic_inv_chain_if #(
    parameter int WIDTH      = 8,
    parameter int STAGES     = 3,
    parameter int RAMP_STEPS = 2
);
    localparam int LW = $clog2(RAMP_STEPS + 1);

    logic                 en;
    logic [WIDTH-1:0]     in;
    logic                 in_ack;
    logic [WIDTH-1:0]     out;
    logic                 out_valid;
    logic [STAGES*LW-1:0] pc_level;

    modport master (
        output en, in,
        input  in_ack, out, out_valid, pc_level
    );

    modport slave (
        input  en, in,
        output in_ack, out, out_valid, pc_level
    );

endinterface

// File: rtl/adiabatic_inv_chain_stage.sv
// One inverting adiabatic stage: data register, primed flag, level decode.
// Ports: step/phase/advance from the generator, d_in + primed_in from upstream.
module adiabatic_stage
    import adiabatic_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int RAMP_STEPS      = 2,
    parameter int LW              = 2,
    parameter int STEP_W          = 1,
    parameter bit LIVE_FROM_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STEP_W-1:0] step,
    input  pc_phase_t         phase,
    input  logic              advance,
    input  logic              primed_in,
    input  logic [WIDTH-1:0]  d_in,
    output logic [WIDTH-1:0]  data,
    output logic              primed,
    output logic [LW-1:0]     level
);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEPS - 1);

    logic capture;

    assign capture = advance && (phase == PC_EVAL) && (step == STEP_LAST);

    // A stage only counts as primed once a word derived from a real input
    // reaches it, so reset-time garbage never surfaces as a valid output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data   <= '0;
            primed <= 1'b0;
        end else if (capture) begin
            data   <= ~d_in;
            primed <= primed_in;
        end
    end

    // The head stage leaves reset in WAIT, so its first ramp is a real charge.
    always_comb begin
        level = '0;
        if (primed || LIVE_FROM_RESET) begin
            unique case (1'b1)
                (phase == PC_WAIT):    level = '0;
                (phase == PC_EVAL):    level = LW'(step) + LW'(1);
                (phase == PC_HOLD):    level = LW'(RAMP_STEPS);
                (phase == PC_RECOVER): level = LW'(RAMP_STEPS - 1) - LW'(step);
                default:               level = '0;
            endcase
        end
    end

endmodule

// File: rtl/adiabatic_inv_chain.sv
// Chain of inverting adiabatic stages with a four-phase stepwise power clock.
// Ports: clk, rst_n (async, active-low), bus (slave: en/in in; ack/out/levels out).
module adiabatic_inv_chain
    import adiabatic_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STAGES     = 3,
    parameter int RAMP_STEPS = 2,
    localparam int LW        = $clog2(RAMP_STEPS + 1)
) (
    input logic                  clk,
    input logic                  rst_n,
    adiabatic_inv_chain_if.slave bus
);

    localparam int STEP_W = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEPS - 1);

    logic [STEP_W-1:0]             step;
    logic [1:0]                    g;
    logic                          stall;
    logic                          advance;
    logic [STAGES-1:0][WIDTH-1:0]  data;
    logic [STAGES-1:0][WIDTH-1:0]  up_data;
    logic [STAGES-1:0]             primed;
    logic [STAGES-1:0]             up_primed;
    logic [STAGES*LW-1:0]          pc_level;
    logic                          out_valid;

    // Stopping only at the period boundary keeps every ramp complete.
    assign stall   = !bus.en && (g == 2'd0) && (step == '0);
    assign advance = !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
            g    <= 2'd0;
        end else if (advance) begin
            if (step == STEP_LAST) begin
                step <= '0;
                g    <= g + 2'd1;
            end else begin
                step <= step + STEP_W'(1);
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up_data[k]   = bus.in;
            assign up_primed[k] = 1'b1;
        end else begin : g_link
            assign up_data[k]   = data[k-1];
            assign up_primed[k] = primed[k-1];
        end

        adiabatic_stage #(
            .WIDTH           (WIDTH),
            .RAMP_STEPS      (RAMP_STEPS),
            .LW              (LW),
            .STEP_W          (STEP_W),
            .LIVE_FROM_RESET (k == 0)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .step      (step),
            .phase     (phase_of(g, k)),
            .advance   (advance),
            .primed_in (up_primed[k]),
            .d_in      (up_data[k]),
            .data      (data[k]),
            .primed    (primed[k]),
            .level     (pc_level[k*LW +: LW])
        );
    end

    assign bus.in_ack = advance
                     && (phase_of(g, 0) == PC_EVAL)
                     && (step == STEP_LAST);

    // A frozen generator presents no word; it reappears once running.
    assign out_valid = primed[STAGES-1]
                    && (phase_of(g, STAGES - 1) == PC_HOLD)
                    && advance;

    assign bus.out_valid = out_valid;
    assign bus.out       = out_valid ? data[STAGES-1] : '0;
    assign bus.pc_level  = pc_level;

endmodule
